// File: rtl/fft_r22sdf_twiddle_gen_pkg.sv
// Shared definitions for the R2^2 SDF twiddle generator: 3x slot codes,
// quadrant codes and the sine-table helpers used at elaboration.
package fft_r22sdf_twiddle_gen_pkg;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        QD_0 = 2'd0,
        QD_1 = 2'd1,
        QD_2 = 2'd2
    } quad_t;

    localparam real TWO_PI = 6.283185307179586;

    // Full-scale twiddle magnitude for a signed w-bit word: 2^(w-1)-1.
    function automatic int twiddle_amp(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Quarter-wave table entry i of an n-point sine, rounded half away from zero.
    function automatic int sine_entry(input int w, input int n, input int i);
        real x;
        x = real'(twiddle_amp(w)) * $sin(TWO_PI * real'(i) / real'(n));
        // x is never negative on the first quarter wave
        return $rtoi(x + 0.5);
    endfunction

endpackage

// File: rtl/fft_twiddle_qrom.sv
// Quarter-wave sine ROM: FFT_N/4+1 unsigned entries, synchronous read.
module fft_twiddle_qrom
    import fft_r22sdf_twiddle_gen_pkg::*;
#(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int FFT_N         = 1024,
    parameter int NLOG2         = 10
) (
    input  logic                     i_clk,
    input  logic [NLOG2-2:0]         i_addr,
    output logic [TWIDDLE_WIDTH-2:0] o_q
);

    localparam int Q  = FFT_N / 4;
    localparam int DW = TWIDDLE_WIDTH - 1;

    logic [DW-1:0] w_table [0:Q];

    for (genvar gi = 0; gi <= Q; gi++) begin : g_tab
        assign w_table[gi] = DW'(sine_entry(TWIDDLE_WIDTH, FFT_N, gi));
    end

    // Registered read port, one-cycle latency.
    always_ff @(posedge i_clk) begin
        o_q <= w_table[i_addr];
    end

endmodule

// File: rtl/fft_r22sdf_twiddle_gen.sv
// Twiddle source W_N^m for an R2^2 SDF stage. One quarter-wave ROM is
// time-shared over the three clk_3x_i slots of each 1x period: the real
// magnitude is fetched first, the imaginary one second, then both are signed
// and presented together with the matching counter value.
module fft_r22sdf_twiddle_gen
    import fft_r22sdf_twiddle_gen_pkg::*;
#(
    parameter int TWIDDLE_WIDTH = 10,
    parameter int FFT_N         = 1024,
    parameter int NLOG2         = 10
) (
    input  logic                            clk_3x_i,
    input  logic                            rst_n,
    input  logic [NLOG2-1:0]                ctr_i,
    output logic [NLOG2-1:0]                ctr_o,
    output logic signed [TWIDDLE_WIDTH-1:0] w_re_o,
    output logic signed [TWIDDLE_WIDTH-1:0] w_im_o,
    output logic [1:0]                      phase_o
);

    localparam int AW = NLOG2 - 1;
    localparam int RW = NLOG2 - 2;
    localparam int MW = TWIDDLE_WIDTH - 1;
    localparam logic [AW-1:0] Q_ADDR = AW'(FFT_N / 4);

    phase_t                 r_phase, w_phase_nxt;
    logic [1:0]             w_b;
    logic [RW-1:0]          w_n2;
    logic [NLOG2-1:0]       w_m;
    quad_t                  r_quad;
    logic [RW-1:0]          r_r;
    logic [NLOG2-1:0]       r_ctr;
    logic                   r_smp_vld;
    logic [AW-1:0]          w_re_addr, w_im_addr;
    logic                   w_re_neg, w_im_neg;
    logic [AW-1:0]          r_rom_addr;
    logic [MW-1:0]          w_rom_q;
    logic [MW-1:0]          r_re_mag;
    logic                   r_re_neg_d, r_im_neg_d;
    logic [NLOG2-1:0]       r_ctr_d;
    logic                   r_mag_vld;

    function automatic logic signed [TWIDDLE_WIDTH-1:0] apply_sign(
        input logic [MW-1:0] mag,
        input logic          neg
    );
        logic signed [TWIDDLE_WIDTH-1:0] ext;
        ext = $signed({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

    // Slot counter state register.
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) r_phase <= PH_0;
        else        r_phase <= w_phase_nxt;
    end

    // Slot counter next state: 0 -> 1 -> 2 -> 0.
    always_comb begin
        w_phase_nxt = PH_0;
        case (r_phase)
            PH_0:    w_phase_nxt = PH_1;
            PH_1:    w_phase_nxt = PH_2;
            default: w_phase_nxt = PH_0;
        endcase
    end

    assign phase_o = r_phase;

    // Twiddle exponent m = n2 * bitrev(b).
    always_comb begin
        w_b  = ctr_i[NLOG2-1 -: 2];
        w_n2 = ctr_i[RW-1:0];
        w_m  = {2'b00, w_n2} * {{RW{1'b0}}, w_b[0], w_b[1]};
    end

    // Slot0: sample the counter and split m into quadrant and offset.
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            r_quad    <= QD_0;
            r_r       <= '0;
            r_ctr     <= '0;
            r_smp_vld <= 1'b0;
        end else if (r_phase == PH_0) begin
            r_quad    <= quad_t'(w_m[NLOG2-1 -: 2]);
            r_r       <= w_m[RW-1:0];
            r_ctr     <= ctr_i;
            r_smp_vld <= 1'b1;
        end
    end

    // Quadrant map to ROM addresses and output signs.
    always_comb begin
        w_re_addr = Q_ADDR - {1'b0, r_r};
        w_im_addr = {1'b0, r_r};
        w_re_neg  = 1'b0;
        w_im_neg  = 1'b1;
        case (r_quad)
            QD_1: begin
                w_re_addr = {1'b0, r_r};
                w_im_addr = Q_ADDR - {1'b0, r_r};
                w_re_neg  = 1'b1;
                w_im_neg  = 1'b1;
            end
            QD_2: begin
                w_re_neg  = 1'b1;
                w_im_neg  = 1'b0;
            end
            default: ;
        endcase
    end

    // Shared ROM address: real part at slot1, imaginary part at slot2.
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
        end else begin
            case (r_phase)
                PH_1:    r_rom_addr <= w_re_addr;
                PH_2:    r_rom_addr <= w_im_addr;
                default: r_rom_addr <= r_rom_addr;
            endcase
        end
    end

    fft_twiddle_qrom #(
        .TWIDDLE_WIDTH (TWIDDLE_WIDTH),
        .FFT_N         (FFT_N),
        .NLOG2         (NLOG2)
    ) u_qrom (
        .i_clk  (clk_3x_i),
        .i_addr (r_rom_addr),
        .o_q    (w_rom_q)
    );

    // Slot0: park the real magnitude and carry signs/ctr past the next sample.
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            r_re_mag   <= '0;
            r_re_neg_d <= 1'b0;
            r_im_neg_d <= 1'b0;
            r_ctr_d    <= '0;
            r_mag_vld  <= 1'b0;
        end else if (r_phase == PH_0) begin
            r_re_mag   <= w_rom_q;
            r_re_neg_d <= w_re_neg;
            r_im_neg_d <= w_im_neg;
            r_ctr_d    <= r_ctr;
            r_mag_vld  <= r_smp_vld;
        end
    end

    // Slot1: apply signs and update outputs; gated so a fetch aborted by reset
    // never leaks unrelated ROM data.
    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            w_re_o <= '0;
            w_im_o <= '0;
            ctr_o  <= '0;
        end else if (r_phase == PH_1 && r_mag_vld) begin
            w_re_o <= apply_sign(r_re_mag, r_re_neg_d);
            w_im_o <= apply_sign(w_rom_q, r_im_neg_d);
            ctr_o  <= r_ctr_d;
        end
    end

endmodule

// File: tb/tb_fft_r22sdf_twiddle_gen.sv
// Scoreboard bench for fft_r22sdf_twiddle_gen (TW=10, N=1024).
module tb_fft_r22sdf_twiddle_gen;

    localparam real PI2 = 6.283185307179586;

    typedef struct {
        int ctr;
        int re;
        int im;
        int tol;
        int due;
    } exp_t;

    logic              clk_3x_i;
    logic              rst_n;
    logic [9:0]        ctr_i;
    logic [9:0]        ctr_o;
    logic signed [9:0] w_re_o;
    logic signed [9:0] w_im_o;
    logic [1:0]        phase_o;

    exp_t sb[$];
    exp_t last;
    bit   last_valid = 0;
    bit   mon_en = 0;
    int   cyc = 0;
    int   exp_phase = 0;
    int   errors = 0;
    int   checks = 0;

    fft_r22sdf_twiddle_gen #(
        .TWIDDLE_WIDTH (10),
        .FFT_N         (1024),
        .NLOG2         (10)
    ) dut (
        .clk_3x_i (clk_3x_i),
        .rst_n    (rst_n),
        .ctr_i    (ctr_i),
        .ctr_o    (ctr_o),
        .w_re_o   (w_re_o),
        .w_im_o   (w_im_o),
        .phase_o  (phase_o)
    );

    initial clk_3x_i = 1'b0;
    always #5 clk_3x_i = ~clk_3x_i;

    always @(posedge clk_3x_i) begin
        cyc <= cyc + 1;
        exp_phase <= (!rst_n) ? 0 : ((exp_phase == 2) ? 0 : exp_phase + 1);
    end

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference twiddle straight from cos/sin of the exponent.
    task automatic model(input int c, output int re, output int im);
        int b, n2, br, m;
        real a;
        b  = (c >> 8) & 3;
        n2 = c & 255;
        br = ((b & 1) << 1) | ((b >> 1) & 1);
        m  = n2 * br;
        a  = PI2 * real'(m) / 1024.0;
        re = rnd(511.0 * $cos(a));
        im = rnd(-511.0 * $sin(a));
    endtask

    task automatic cmp_out(input string name, input exp_t e);
        checks++;
        if (int'(ctr_o) != e.ctr || iabs(int'(w_re_o) - e.re) > e.tol ||
            iabs(int'(w_im_o) - e.im) > e.tol) begin
            errors++;
            $display("FAIL %s @cyc %0d: got ctr=%0d re=%0d im=%0d, want ctr=%0d re=%0d im=%0d (tol %0d)",
                     name, cyc, ctr_o, w_re_o, w_im_o, e.ctr, e.re, e.im, e.tol);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, got, want);
        end
    endtask

    // Drive one counter value at the next slot0 edge and queue its expectation.
    task automatic send(input int c, input int re, input int im, input int tol);
        exp_t e;
        int   n;
        n = 0;
        while (exp_phase != 0 && n < 5) begin
            @(negedge clk_3x_i);
            n++;
        end
        if (exp_phase != 0) begin
            errors++;
            checks++;
            $display("FAIL send_slot0 @cyc %0d: phase %0d, want 0", cyc, exp_phase);
        end
        ctr_i = 10'(c);
        e.ctr = c; e.re = re; e.im = im; e.tol = tol;
        e.due = cyc + 5;
        sb.push_back(e);
    endtask

    task automatic send_model(input int c);
        int re, im;
        model(c, re, im);
        send(c, re, im, 1);
        @(negedge clk_3x_i);
    endtask

    // Monitor: pop at the output update, otherwise check the held value.
    always @(negedge clk_3x_i) begin
        if (mon_en) begin
            cmp_int("phase", int'(phase_o), exp_phase);
            if (sb.size() > 0 && sb[0].due < cyc) begin
                errors++;
                checks++;
                $display("FAIL timeout: ctr=%0d due cyc %0d not observed, now %0d",
                         sb[0].ctr, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (exp_phase == 2 && sb.size() > 0 && sb[0].due == cyc) begin
                last = sb.pop_front();
                last_valid = 1;
                cmp_out("update", last);
            end else if (last_valid) begin
                cmp_out("hold", last);
            end else begin
                cmp_int("idle_re", int'(w_re_o), 0);
                cmp_int("idle_im", int'(w_im_o), 0);
                cmp_int("idle_ctr", int'(ctr_o), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ctr_i = '0;
        repeat (4) @(negedge clk_3x_i);
        cmp_int("rst_phase", int'(phase_o), 0);
        cmp_int("rst_re", int'(w_re_o), 0);
        cmp_int("rst_im", int'(w_im_o), 0);
        cmp_int("rst_ctr", int'(ctr_o), 0);

        rst_n  = 1'b1;
        mon_en = 1;

        // Directed vectors, hand-computed
        send(0,   511,    0, 0); @(negedge clk_3x_i);
        send(384,   0, -511, 0); @(negedge clk_3x_i);
        send(513, 511,   -3, 0); @(negedge clk_3x_i);
        send(938, -511,  -6, 0); @(negedge clk_3x_i);
        send(767,   3, -511, 0); @(negedge clk_3x_i);
        send(1023, -9,  511, 0); @(negedge clk_3x_i);
        send(255, 511,    0, 0); @(negedge clk_3x_i);
        repeat (12) @(negedge clk_3x_i);

        // Free-run sweep, twice, including the 1023 -> 0 wrap
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 1024; c++)
                send_model(c);

        // Mid-stream reset at slot1
        for (int c = 100; c < 105; c++) send_model(c);
        while (exp_phase != 1) @(negedge clk_3x_i);
        #1;
        rst_n = 1'b0;
        sb.delete();
        last_valid = 0;
        @(negedge clk_3x_i);
        rst_n = 1'b1;
        cmp_int("midrst_phase", int'(phase_o), 0);
        cmp_int("midrst_re", int'(w_re_o), 0);
        cmp_int("midrst_im", int'(w_im_o), 0);
        cmp_int("midrst_ctr", int'(ctr_o), 0);
        send(384, 0, -511, 0); @(negedge clk_3x_i);
        send(513, 511, -3, 0); @(negedge clk_3x_i);
        send(938, -511, -6, 0); @(negedge clk_3x_i);

        // Drain
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk_3x_i);
        if (sb.size() > 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("FAIL drain: %0d expected outputs never observed", sb.size());
        end
        @(negedge clk_3x_i);
        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
